// File: rtl/program_loader.sv
// program_loader: UART (8N1) boot loader that writes a framed image into instruction memory.
// Ports: clk, reset (sync, active-high), rx -> imemWriteEnable/imemAddress/imemWriteData, cpuHold, loadDone, frameError.
`timescale 1ns/1ps
module program_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         ADDR_WIDTH   = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  imemWriteEnable,
    output logic [ADDR_WIDTH-1:0] imemAddress,
    output logic [31:0]           imemWriteData,
    output logic                  cpuHold,
    output logic                  loadDone,
    output logic                  frameError
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] WAIT_SYNC = 2'd0;
    localparam logic [1:0] GET_COUNT = 2'd1;
    localparam logic [1:0] GET_DATA  = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    logic          rxMeta;
    logic          rxSync;
    logic          rxPrev;
    logic [1:0]    rxState;
    logic [CW-1:0] clkCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    rxByte;

    logic          byteValid;
    logic          stopError;

    logic [1:0]    frameState;
    logic [8:0]    wordCount;
    logic [8:0]    wordIdx;
    logic [1:0]    byteIdx;
    logic [23:0]   wordShift;

    // Stop-bit verdicts are combinational so the write strobe lands
    // exactly one cycle after the final stop-bit sample.
    assign byteValid = (rxState == RX_STOP) && (clkCnt == BIT_LAST) && rxSync;
    assign stopError = (rxState == RX_STOP) && (clkCnt == BIT_LAST) && !rxSync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta  <= 1'b1;
            rxSync  <= 1'b1;
            rxPrev  <= 1'b1;
            rxState <= RX_IDLE;
            clkCnt  <= '0;
            bitIdx  <= '0;
            rxByte  <= '0;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
            unique case (rxState)
                RX_IDLE: begin
                    clkCnt <= '0;
                    bitIdx <= '0;
                    if (rxPrev && !rxSync) begin
                        rxState <= RX_START;
                    end
                end
                RX_START: begin
                    if (clkCnt == HALF_LAST) begin
                        clkCnt  <= '0;
                        // A line that is high again mid start-bit is a glitch.
                        rxState <= rxSync ? RX_IDLE : RX_DATA;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clkCnt == BIT_LAST) begin
                        clkCnt <= '0;
                        rxByte <= {rxSync, rxByte[7:1]};
                        if (bitIdx == 3'd7) begin
                            rxState <= RX_STOP;
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clkCnt == BIT_LAST) begin
                        clkCnt  <= '0;
                        rxState <= RX_IDLE;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frameState      <= WAIT_SYNC;
            wordCount       <= '0;
            wordIdx         <= '0;
            byteIdx         <= '0;
            wordShift       <= '0;
            imemWriteEnable <= 1'b0;
            imemAddress     <= '0;
            imemWriteData   <= '0;
            cpuHold         <= 1'b1;
            loadDone        <= 1'b0;
            frameError      <= 1'b0;
        end else begin
            imemWriteEnable <= 1'b0;
            if (imemWriteEnable) begin
                imemAddress <= imemAddress + 1'b1;
            end
            // State already moved to DONE with the final strobe.
            if (imemWriteEnable && frameState == DONE) begin
                cpuHold  <= 1'b0;
                loadDone <= 1'b1;
            end
            if (frameState != DONE) begin
                if (stopError) begin
                    frameError  <= 1'b1;
                    frameState  <= WAIT_SYNC;
                    imemAddress <= '0;
                    byteIdx     <= '0;
                end else if (byteValid) begin
                    unique case (frameState)
                        WAIT_SYNC: begin
                            if (rxByte == SYNC_BYTE) begin
                                frameState <= GET_COUNT;
                            end
                        end
                        GET_COUNT: begin
                            wordCount   <= (rxByte == 8'd0) ? 9'd256 : {1'b0, rxByte};
                            wordIdx     <= '0;
                            byteIdx     <= '0;
                            imemAddress <= '0;
                            frameState  <= GET_DATA;
                        end
                        GET_DATA: begin
                            wordShift <= {wordShift[15:0], rxByte};
                            byteIdx   <= byteIdx + 1'b1;
                            if (byteIdx == 2'd3) begin
                                imemWriteEnable <= 1'b1;
                                imemWriteData   <= {wordShift, rxByte};
                                wordIdx         <= wordIdx + 1'b1;
                                if (wordIdx + 9'd1 == wordCount) begin
                                    frameState <= DONE;
                                end
                            end
                        end
                        default: frameState <= WAIT_SYNC;
                    endcase
                end
            end
        end
    end

endmodule
